// File: rtl/ddr3_burst_arbiter_if.sv
// Bundles the requester-side and DDR3 application-port signals of ddr3_burst_arbiter.
// The master modport is the arbiter; the slave modport is the requesters plus the DDR3 IP.
interface ddr3_burst_arbiter_if #(
    parameter int ADDR_WIDTH     = 27,
    parameter int APP_DATA_WIDTH = 128
);
    logic                      init_done;

    logic                      wr_req;
    logic [ADDR_WIDTH-1:0]     wr_addr;
    logic                      wr_ack;
    logic                      wr_data_req;
    logic [APP_DATA_WIDTH-1:0] wr_data;
    logic                      wr_done;

    logic                      rd_req;
    logic [ADDR_WIDTH-1:0]     rd_addr;
    logic                      rd_ack;
    logic [APP_DATA_WIDTH-1:0] rd_data;
    logic                      rd_data_valid;
    logic                      rd_done;

    logic                      busy;
    logic                      proto_err;

    logic [2:0]                cmd;
    logic                      cmd_en;
    logic                      cmd_rdy;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [APP_DATA_WIDTH-1:0] ddr3_wr_data;
    logic                      ddr3_wren;
    logic                      ddr3_wr_end;
    logic                      ddr3_wr_rdy;
    logic [APP_DATA_WIDTH-1:0] ddr3_rd_data;
    logic                      ddr3_rd_valid;

    modport master (
        input  init_done, wr_req, wr_addr, wr_data, rd_req, rd_addr,
               cmd_rdy, ddr3_wr_rdy, ddr3_rd_data, ddr3_rd_valid,
        output wr_ack, wr_data_req, wr_done, rd_ack, rd_data, rd_data_valid,
               rd_done, busy, proto_err, cmd, cmd_en, addr,
               ddr3_wr_data, ddr3_wren, ddr3_wr_end
    );

    modport slave (
        output init_done, wr_req, wr_addr, wr_data, rd_req, rd_addr,
               cmd_rdy, ddr3_wr_rdy, ddr3_rd_data, ddr3_rd_valid,
        input  wr_ack, wr_data_req, wr_done, rd_ack, rd_data, rd_data_valid,
               rd_done, busy, proto_err, cmd, cmd_en, addr,
               ddr3_wr_data, ddr3_wren, ddr3_wr_end
    );
endinterface

// File: rtl/ddr3_burst_arbiter.sv
// Shares the DDR3 application port between the frame-buffer write path and the display read path.
// Define DDR3_ARB_FAIR_EN for round-robin arbitration; otherwise read has fixed priority.
module ddr3_burst_arbiter #(
    parameter int ADDR_WIDTH     = 27,
    parameter int APP_DATA_WIDTH = 128,
    parameter int BURST_BEATS    = 8
) (
    input  logic                 ref_clk,
    input  logic                 rst,
    ddr3_burst_arbiter_if.master bus
);

    localparam int              CNT_W     = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_CMD,
        WR_DATA,
        RD_CMD,
        RD_WAIT
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [CNT_W-1:0]          beat_cnt;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [2:0]                cmd_q;
    logic [APP_DATA_WIDTH-1:0] rd_data_q;
    logic                      rd_data_valid_q;
    logic                      rd_done_q;
    logic                      proto_err_q;
    logic                      grant_wr;
    logic                      grant_rd;

`ifdef DDR3_ARB_FAIR_EN
    logic last_grant_rd;

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            last_grant_rd <= 1'b0;
        end else if (grant_wr || grant_rd) begin
            last_grant_rd <= grant_rd;
        end
    end

    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (state == IDLE && bus.init_done) begin
            if (bus.wr_req && bus.rd_req) begin
                grant_rd = !last_grant_rd;
                grant_wr = last_grant_rd;
            end else if (bus.rd_req) begin
                grant_rd = 1'b1;
            end else if (bus.wr_req) begin
                grant_wr = 1'b1;
            end
        end
    end
`else
    // The display read path has a hard deadline, so it always wins a tie.
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (state == IDLE && bus.init_done) begin
            if (bus.rd_req) begin
                grant_rd = 1'b1;
            end else if (bus.wr_req) begin
                grant_wr = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_next       = state;
        bus.cmd_en       = 1'b0;
        bus.wr_ack       = 1'b0;
        bus.rd_ack       = 1'b0;
        bus.wr_data_req  = 1'b0;
        bus.ddr3_wren    = 1'b0;
        bus.ddr3_wr_end  = 1'b0;
        bus.ddr3_wr_data = '0;
        bus.wr_done      = 1'b0;
        case (state)
            IDLE: begin
                if (grant_wr) begin
                    state_next = WR_CMD;
                end else if (grant_rd) begin
                    state_next = RD_CMD;
                end
            end
            WR_CMD: begin
                bus.cmd_en = 1'b1;
                if (bus.cmd_rdy) begin
                    bus.wr_ack = 1'b1;
                    state_next = WR_DATA;
                end
            end
            WR_DATA: begin
                // Show-ahead FIFO: the head word goes straight to the IP while it is ready.
                bus.ddr3_wren    = bus.ddr3_wr_rdy;
                bus.wr_data_req  = bus.ddr3_wr_rdy;
                bus.ddr3_wr_data = bus.wr_data;
                if (bus.ddr3_wr_rdy && beat_cnt == LAST_BEAT) begin
                    bus.ddr3_wr_end = 1'b1;
                    bus.wr_done     = 1'b1;
                    state_next      = IDLE;
                end
            end
            RD_CMD: begin
                bus.cmd_en = 1'b1;
                if (bus.cmd_rdy) begin
                    bus.rd_ack = 1'b1;
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (bus.ddr3_rd_valid && beat_cnt == LAST_BEAT) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            state           <= IDLE;
            beat_cnt        <= '0;
            addr_q          <= '0;
            cmd_q           <= 3'b000;
            rd_data_q       <= '0;
            rd_data_valid_q <= 1'b0;
            rd_done_q       <= 1'b0;
            proto_err_q     <= 1'b0;
        end else begin
            state           <= state_next;
            rd_data_valid_q <= 1'b0;
            rd_done_q       <= 1'b0;

            if (grant_wr) begin
                addr_q <= bus.wr_addr;
                cmd_q  <= 3'b000;
            end else if (grant_rd) begin
                addr_q <= bus.rd_addr;
                cmd_q  <= 3'b001;
            end

            if (state == WR_CMD || state == RD_CMD) begin
                beat_cnt <= '0;
            end else if ((state == WR_DATA && bus.ddr3_wr_rdy) ||
                         (state == RD_WAIT && bus.ddr3_rd_valid)) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end

            // A read beat outside a granted read has nowhere to go; drop it and flag it.
            if (bus.ddr3_rd_valid) begin
                if (state == RD_WAIT) begin
                    rd_data_q       <= bus.ddr3_rd_data;
                    rd_data_valid_q <= 1'b1;
                    rd_done_q       <= (beat_cnt == LAST_BEAT);
                end else begin
                    proto_err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.addr          = addr_q;
    assign bus.cmd           = cmd_q;
    assign bus.rd_data       = rd_data_q;
    assign bus.rd_data_valid = rd_data_valid_q;
    assign bus.rd_done       = rd_done_q;
    assign bus.proto_err     = proto_err_q;
    assign bus.busy          = (state != IDLE);

endmodule

// File: doc/ddr3_burst_arbiter.md
# ddr3_burst_arbiter

Shares the single DDR3 IP application port between the frame-buffer write path (UDP-to-DDR3 pixel bursts) and the display read path (DDR3-to-HDMI line prefetch). Sits between the frame-buffer controller's two burst requesters and the DDR3 memory interface in the `ref_clk` (`memory_clk_div4`) domain. Grants one burst at a time, sequences command, data-beat and completion handshakes, and returns read beats to the read requester.

## Interface
- `ADDR_WIDTH`, 27, DDR3 application address width.
- `APP_DATA_WIDTH`, 128, DDR3 application data width.
- `BURST_BEATS`, 8, app data beats per burst (matches `app_burst_number` = 7).
- `ref_clk` in 1: sole clock, DDR3 user clock.
- `rst` in 1: synchronous, active-high reset.
- `init_done` in 1: DDR3 calibration complete.
- `wr_req` in 1: write burst pending, level, held until `wr_ack`.
- `wr_addr` in ADDR_WIDTH: write burst start address, stable while `wr_req`.
- `wr_ack` out 1: one-cycle pulse, write command accepted by IP.
- `wr_data_req` out 1: pop one beat from write FIFO (show-ahead).
- `wr_data` in APP_DATA_WIDTH: FIFO head, valid same cycle as `wr_data_req`.
- `wr_done` out 1: one-cycle pulse, last write beat transferred.
- `rd_req` in 1: read burst pending, level, held until `rd_ack`.
- `rd_addr` in ADDR_WIDTH: read burst start address.
- `rd_ack` out 1: one-cycle pulse, read command accepted.
- `rd_data` out APP_DATA_WIDTH: registered read beat.
- `rd_data_valid` out 1: `rd_data` valid.
- `rd_done` out 1: one-cycle pulse with last read beat.
- `busy` out 1: FSM not in IDLE.
- `proto_err` out 1: sticky; stray `ddr3_rd_valid` outside RD_WAIT.
- `cmd` out 3: 3'b000 write, 3'b001 read.
- `cmd_en` out 1, `cmd_rdy` in 1: command handshake.
- `addr` out ADDR_WIDTH: command address.
- `ddr3_wr_data` out APP_DATA_WIDTH, `ddr3_wren` out 1, `ddr3_wr_end` out 1, `ddr3_wr_rdy` in 1.
- `ddr3_rd_data` in APP_DATA_WIDTH, `ddr3_rd_valid` in 1.

## Operation
- States: IDLE, WR_CMD, WR_DATA, RD_CMD, RD_WAIT.
- IDLE: no grant while `init_done`=0. Else grant per arbitration policy; latch address; go to WR_CMD or RD_CMD.
- WR_CMD/RD_CMD: drive `cmd_en`=1, `cmd`, `addr` stable until `cmd_rdy`=1 sampled; that cycle pulses `wr_ack`/`rd_ack`. Next state WR_DATA / RD_WAIT; beat counter cleared.
- WR_DATA: `ddr3_wren` = `wr_data_req` = `ddr3_wr_rdy`; `ddr3_wr_data` = `wr_data` (combinational). `ddr3_wr_end` = `ddr3_wren` on beat BURST_BEATS-1. After final beat pulse `wr_done`, return IDLE.
- RD_WAIT: each `ddr3_rd_valid` registers `ddr3_rd_data` to `rd_data`, asserts `rd_data_valid` next cycle; beat BURST_BEATS-1 also asserts `rd_done` with it; return IDLE.
- `ddr3_rd_valid` in any other state: beat dropped, `proto_err` set until `rst`.
- Requests sampled only in IDLE; a granted burst always completes. Beat counter width clog2(BURST_BEATS), no wrap within a burst.
- `init_done` falling mid-burst: ignored until IDLE.

## Timing
- Reset values: `cmd_en`,`ddr3_wren`,`ddr3_wr_end`,`wr_data_req`,`wr_ack`,`rd_ack`,`wr_done`,`rd_done`,`rd_data_valid`,`busy`,`proto_err` = 0; `cmd`=3'b000; `addr`,`rd_data`=0; state IDLE.
- Request to `cmd_en`: 1 cycle (request seen in IDLE cycle N, `cmd_en` high N+1).
- Minimum write burst: 1 + 1 + BURST_BEATS cycles with `cmd_rdy`,`ddr3_wr_rdy` constantly high; first beat the cycle after the command handshake.
- Read data latency through block: 1 cycle.
- Back-to-back: IDLE lasts one cycle between bursts.
- `rst` mid-burst: all outputs to reset values next edge; partial burst abandoned (IP is reset alongside).

## Configuration
- `DDR3_ARB_FAIR_EN` defined: round-robin; when both requests pending in IDLE, grant the port not granted last (last-grant flag resets to write, so read wins first tie). Single pending request always granted.
- Undefined: fixed priority; read always wins a tie (display has hard real-time deadline).

## Test plan
- Reset then `init_done`=0 with `wr_req`=1 -> no `cmd_en` for 100 cycles; raise `init_done` -> `cmd_en`=1, `cmd`=3'b000 one cycle later.
- Write burst `wr_addr`=27'h0000400, `cmd_rdy` low 3 cycles, `ddr3_wr_rdy` toggling -> `addr` stable, one `wr_ack`, exactly 8 `ddr3_wren` beats, `ddr3_wr_end` only on 8th, `wr_done` once.
- Read burst `rd_addr`=27'h0000200, 8 `ddr3_rd_valid` beats with gaps, data 0..7 -> `rd_data` 0..7 one cycle late, `rd_done` with beat 7.
- Both requests held continuously for 4 bursts -> default: R,R,R,R; with `DDR3_ARB_FAIR_EN`: R,W,R,W.
- `ddr3_rd_valid` pulse in IDLE -> `proto_err`=1, no `rd_data_valid`; stays 1 until `rst`.
- `rst` asserted at beat 4 of a write -> all outputs zero next cycle, new `wr_req` restarts from WR_CMD.
